// File: rtl/csr_timer.sv
// LoongArch CSR timer block: TID, TCFG, TVAL, TICLR and the 64-bit stable counter.
// Read data and hit flag feed the CSR file's read mux; timer_int drives ESTAT.IS[11].
module csr_timer #(
    parameter logic [31:0] TID_RESET     = 32'h0,
    parameter logic [8:0]  CSR_TID_NUM   = 9'h40,
    parameter logic [8:0]  CSR_TCFG_NUM  = 9'h41,
    parameter logic [8:0]  CSR_TVAL_NUM  = 9'h42,
    parameter logic [8:0]  CSR_TICLR_NUM = 9'h44
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  csr_num,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic [31:0] csr_rvalue,
    output logic        csr_hit,
    output logic        timer_int,
    output logic [63:0] stable_cnt
);

    localparam logic [31:0] CNT_IDLE = 32'hFFFF_FFFF;

    logic [31:0] tid;
    logic        tcfg_en;
    logic        tcfg_periodic;
    logic [29:0] tcfg_initval;
    logic [31:0] timer_cnt;

    logic [31:0] tcfg_cur;
    logic [31:0] tcfg_new;
    logic [31:0] tid_new;
    logic        tid_wr;
    logic        tcfg_wr;
    logic        ticlr_wr;
    logic        ti_clear;
    logic        ti_set;

    function automatic logic [31:0] masked_write(input logic [31:0] mask,
                                                 input logic [31:0] value,
                                                 input logic [31:0] old);
        return (mask & value) | (~mask & old);
    endfunction

    assign tcfg_cur = {tcfg_initval, tcfg_periodic, tcfg_en};
    assign tcfg_new = masked_write(csr_wmask, csr_wvalue, tcfg_cur);
    assign tid_new  = masked_write(csr_wmask, csr_wvalue, tid);

    assign tid_wr   = csr_we && (csr_num == CSR_TID_NUM);
    assign tcfg_wr  = csr_we && (csr_num == CSR_TCFG_NUM);
    assign ticlr_wr = csr_we && (csr_num == CSR_TICLR_NUM);
    assign ti_clear = ticlr_wr && csr_wmask[0] && csr_wvalue[0];
    assign ti_set   = tcfg_en && (timer_cnt == 32'h0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tid           <= TID_RESET;
            tcfg_en       <= 1'b0;
            tcfg_periodic <= 1'b0;
            tcfg_initval  <= 30'h0;
            timer_cnt     <= CNT_IDLE;
            timer_int     <= 1'b0;
            stable_cnt    <= 64'h0;
        end else begin
            stable_cnt <= stable_cnt + 64'h1;

            if (tid_wr) begin
                tid <= tid_new;
            end

            if (tcfg_wr) begin
                tcfg_en       <= tcfg_new[0];
                tcfg_periodic <= tcfg_new[1];
                tcfg_initval  <= tcfg_new[31:2];
            end

            // A TCFG write always wins over counting: load when enabling, freeze otherwise.
            if (tcfg_wr) begin
                if (tcfg_new[0]) begin
                    timer_cnt <= {tcfg_new[31:2], 2'b00};
                end
            end else if (tcfg_en && (timer_cnt != CNT_IDLE)) begin
                if ((timer_cnt == 32'h0) && tcfg_periodic) begin
                    timer_cnt <= {tcfg_initval, 2'b00};
                end else begin
                    timer_cnt <= timer_cnt - 32'h1;
                end
            end

            // Set beats a same-cycle clear so a zero crossing is never lost.
            if (ti_set) begin
                timer_int <= 1'b1;
            end else if (ti_clear) begin
                timer_int <= 1'b0;
            end
        end
    end

    always_comb begin
        csr_rvalue = 32'h0;
        csr_hit    = 1'b1;
        case (csr_num)
            CSR_TID_NUM:   csr_rvalue = tid;
            CSR_TCFG_NUM:  csr_rvalue = tcfg_cur;
            CSR_TVAL_NUM:  csr_rvalue = timer_cnt;
            CSR_TICLR_NUM: csr_rvalue = 32'h0;
            default:       csr_hit    = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_csr_timer.sv
// Bench for csr_timer: table of directed vectors, hand-written timer sequences,
// then random CSR traffic compared every cycle against a rule-level model.
module tb_csr_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [31:0] csr_rvalue;
    logic        csr_hit;
    logic        timer_int;
    logic [63:0] stable_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_timer dut (
        .clk        (clk),
        .reset      (reset),
        .csr_num    (csr_num),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .csr_rvalue (csr_rvalue),
        .csr_hit    (csr_hit),
        .timer_int  (timer_int),
        .stable_cnt (stable_cnt)
    );

    // Reference state kept as plain architectural values
    logic [31:0] m_tid;
    logic [31:0] m_cfg;
    longint unsigned m_cnt;
    logic        m_ti;
    logic [63:0] m_stable;

    typedef struct {
        logic [8:0]  num;
        logic        we;
        logic [31:0] mask;
        logic [31:0] val;
        logic [31:0] exp_rv;
        logic        exp_hit;
        logic        exp_int;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_hit(input logic [8:0] num);
        return (num == 9'h40) || (num == 9'h41) || (num == 9'h42) || (num == 9'h44);
    endfunction

    function automatic logic [31:0] m_read(input logic [8:0] num);
        if (num == 9'h40) return m_tid;
        if (num == 9'h41) return m_cfg;
        if (num == 9'h42) return 32'(m_cnt);
        return 32'h0;
    endfunction

    task automatic m_reset();
        m_tid    = 32'h0;
        m_cfg    = 32'h0;
        m_cnt    = 64'hFFFF_FFFF;
        m_ti     = 1'b0;
        m_stable = 64'h0;
    endtask

    task automatic m_step(input logic rst, input logic [8:0] num, input logic we,
                          input logic [31:0] mask, input logic [31:0] val);
        logic [31:0]     cfg_next;
        longint unsigned cnt_next;
        longint unsigned period;
        logic            en;
        logic            ti_next;
        if (rst) begin
            m_reset();
            return;
        end
        en       = m_cfg[0];
        period   = longint'(m_cfg >> 2) * 4;
        cfg_next = m_cfg;
        if (we && num == 9'h41) cfg_next = (mask & val) | (~mask & m_cfg);
        ti_next = m_ti;
        if (we && num == 9'h44 && mask[0] && val[0]) ti_next = 1'b0;
        if (en && m_cnt == 0) ti_next = 1'b1;
        cnt_next = m_cnt;
        if (we && num == 9'h41) begin
            if (cfg_next[0]) cnt_next = longint'(cfg_next >> 2) * 4;
        end else if (en && m_cnt != 64'hFFFF_FFFF) begin
            if (m_cnt == 0 && m_cfg[1]) cnt_next = period;
            else if (m_cnt == 0) cnt_next = 64'hFFFF_FFFF;
            else cnt_next = m_cnt - 1;
        end
        if (we && num == 9'h40) m_tid = (mask & val) | (~mask & m_tid);
        m_cfg    = cfg_next;
        m_cnt    = cnt_next;
        m_ti     = ti_next;
        m_stable = m_stable + 64'h1;
    endtask

    // Drive one cycle, compare DUT outputs with the model, then advance past the edge.
    task automatic cycle(input logic rst, input logic [8:0] num, input logic we,
                         input logic [31:0] mask, input logic [31:0] val);
        reset      = rst;
        csr_num    = num;
        csr_we     = we;
        csr_wmask  = mask;
        csr_wvalue = val;
        #1;
        chk("rvalue", csr_rvalue, m_read(num));
        chk("hit", csr_hit, m_hit(num));
        chk("timer_int", timer_int, m_ti);
        chk("stable_cnt", stable_cnt, m_stable);
        m_step(rst, num, we, mask, val);
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [8:0] num);
        cycle(1'b0, num, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [8:0]  rnum;
        logic [31:0] rmask;
        logic [31:0] rval;
        logic        rwe;
        logic        rrst;

        tbl[0]  = '{9'h42, 1'b0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[1]  = '{9'h41, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0};
        tbl[2]  = '{9'h40, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0};
        tbl[3]  = '{9'h44, 1'b0, 32'h0,         32'h0,         32'h0,         1'b1, 1'b0};
        tbl[4]  = '{9'h05, 1'b0, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0};
        tbl[5]  = '{9'h40, 1'b1, 32'hFFFF_0000, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b0};
        tbl[6]  = '{9'h40, 1'b0, 32'h0,         32'h0,         32'hDEAD_0000, 1'b1, 1'b0};
        tbl[7]  = '{9'h41, 1'b1, 32'hFFFF_FFFF, 32'h11,        32'h0,         1'b1, 1'b0};
        tbl[8]  = '{9'h42, 1'b0, 32'h0,         32'h0,         32'd16,        1'b1, 1'b0};
        tbl[9]  = '{9'h41, 1'b0, 32'h0,         32'h0,         32'h11,        1'b1, 1'b0};
        tbl[10] = '{9'h42, 1'b0, 32'h0,         32'h0,         32'd14,        1'b1, 1'b0};
        tbl[11] = '{9'h42, 1'b1, 32'hFFFF_FFFF, 32'h1234,      32'd13,        1'b1, 1'b0};
        tbl[12] = '{9'h42, 1'b0, 32'h0,         32'h0,         32'd12,        1'b1, 1'b0};
        tbl[13] = '{9'h44, 1'b1, 32'h1,         32'h1,         32'h0,         1'b1, 1'b0};
        tbl[14] = '{9'h42, 1'b0, 32'h0,         32'h0,         32'd10,        1'b1, 1'b0};

        reset = 1'b1; csr_num = 9'h0; csr_we = 1'b0; csr_wmask = 32'h0; csr_wvalue = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();

        // Reset state, decode and one-shot start
        for (int i = 0; i < 15; i++) begin
            reset = 1'b0; csr_num = tbl[i].num; csr_we = tbl[i].we;
            csr_wmask = tbl[i].mask; csr_wvalue = tbl[i].val;
            #1;
            chk($sformatf("vec%0d_rvalue", i), csr_rvalue, tbl[i].exp_rv);
            chk($sformatf("vec%0d_hit", i), csr_hit, tbl[i].exp_hit);
            chk($sformatf("vec%0d_int", i), timer_int, tbl[i].exp_int);
            cycle(1'b0, tbl[i].num, tbl[i].we, tbl[i].mask, tbl[i].val);
        end

        // One-shot countdown to zero, wrap to idle, TI latched once
        for (int k = 9; k >= 0; k--) begin
            chk("oneshot_tval", csr_rvalue, 32'(k));
            chk("oneshot_int_low", timer_int, 1'b0);
            rd(9'h42);
        end
        for (int k = 0; k < 3; k++) begin
            chk("oneshot_idle", csr_rvalue, 32'hFFFF_FFFF);
            chk("oneshot_int_high", timer_int, 1'b1);
            rd(9'h42);
        end

        // Periodic InitVal=2 and TICLR clear / re-assert
        cycle(1'b0, 9'h41, 1'b1, 32'hFFFF_FFFF, 32'h0000_000B);
        chk("per_tcfg", csr_rvalue, 32'h0000_000B);
        chk("per_int_kept", timer_int, 1'b1);
        cycle(1'b0, 9'h44, 1'b1, 32'h1, 32'h1);
        chk("ticlr_clears", timer_int, 1'b0);
        for (int k = 6; k >= 0; k--) begin
            rd(9'h42);
            chk("per_tval", csr_rvalue, 32'(k));
        end
        rd(9'h42);
        chk("per_reload", csr_rvalue, 32'd8);
        chk("per_int_reassert", timer_int, 1'b1);

        // TICLR in the same cycle the counter is zero: set wins
        cycle(1'b0, 9'h44, 1'b1, 32'h1, 32'h1);
        chk("ticlr_clears2", timer_int, 1'b0);
        repeat (7) rd(9'h42);
        chk("at_zero", csr_rvalue, 32'h0);
        cycle(1'b0, 9'h44, 1'b1, 32'h1, 32'h1);
        chk("set_beats_clear", timer_int, 1'b1);

        // Reset in the middle of periodic operation
        cycle(1'b1, 9'h41, 1'b0, 32'h0, 32'h0);
        chk("rst_tcfg", csr_rvalue, 32'h0);
        chk("rst_int", timer_int, 1'b0);
        chk("rst_stable", stable_cnt, 64'h0);
        for (int k = 1; k <= 3; k++) begin
            rd(9'h42);
            chk("rst_tval", csr_rvalue, 32'hFFFF_FFFF);
            chk("stable_inc", stable_cnt, 64'(k));
        end

        // Masked En clear freezes TVAL; TVAL writes are ignored
        cycle(1'b0, 9'h41, 1'b1, 32'hFFFF_FFFF, 32'h11);
        rd(9'h42);
        rd(9'h42);
        cycle(1'b0, 9'h41, 1'b1, 32'h1, 32'h0);
        chk("mask_tcfg", csr_rvalue, 32'h10);
        rd(9'h42);
        chk("freeze_tval", csr_rvalue, 32'd14);
        cycle(1'b0, 9'h42, 1'b1, 32'hFFFF_FFFF, 32'h1234);
        chk("tval_ro", csr_rvalue, 32'd14);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0: rnum = 9'h40;
                1, 2: rnum = 9'h41;
                3: rnum = 9'h42;
                4: rnum = 9'h44;
                default: rnum = 9'($urandom);
            endcase
            rwe   = ($urandom_range(0, 3) == 0);
            rmask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            rval  = $urandom;
            if (rnum == 9'h41) rval = {27'($urandom_range(0, 5)), 3'b000, rval[1:0]};
            rrst  = ($urandom_range(0, 255) == 0);
            cycle(rrst, rnum, rwe, rmask, rval);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
